// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the memory port arbiter
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } arb_state_t;

    localparam logic SEL_IF = 1'b0;
    localparam logic SEL_DM = 1'b1;

    localparam int MEM_LAT_MIN = 1;
    localparam int MEM_LAT_MAX = 15;
    localparam int CNT_W       = 4;

endpackage

// File: rtl/mem_arb_perf_ctr.sv
// rtl/mem_arb_perf_ctr.sv - saturating 32-bit event counter
module mem_arb_perf_ctr (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic [31:0] count
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + 32'd1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data arbiter for a shared fixed-latency memory port
// Optional wait-cycle counters are built when MEM_ARB_PERF_EN is defined.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    output logic              stall_f,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_valid,
    output logic              stall_m,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [31:0]       perf_if_wait,
    output logic [31:0]       perf_dm_wait
`endif
);

    localparam int LAT_EFF = (MEM_LAT < MEM_LAT_MIN) ? MEM_LAT_MIN :
                             (MEM_LAT > MEM_LAT_MAX) ? MEM_LAT_MAX : MEM_LAT;
    localparam logic [CNT_W-1:0] LAT_CNT = CNT_W'(LAT_EFF);

    arb_state_t       state;
    arb_state_t       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             sel;
    logic             grant;
    logic             capture;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            sel       <= SEL_IF;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
            if_valid  <= 1'b0;
            dm_valid  <= 1'b0;
        end else begin
            state  <= state_nxt;
            mem_en <= grant;
            // Write enable travels with the single command strobe only.
            mem_we <= grant & dm_req & dm_we;
            if (grant) begin
                sel       <= dm_req ? SEL_DM : SEL_IF;
                mem_addr  <= dm_req ? dm_addr : if_addr;
                mem_wdata <= dm_wdata;
                cnt       <= LAT_CNT;
            end else if ((state == WAIT) && (cnt != '0)) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (capture && (sel == SEL_IF)) begin
                if_rdata <= mem_rdata;
            end
            if (capture && (sel == SEL_DM)) begin
                dm_rdata <= mem_rdata;
            end
            if_valid <= capture && (sel == SEL_IF);
            dm_valid <= capture && (sel == SEL_DM);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (dm_req || if_req) state_nxt = WAIT;
            WAIT:    if (cnt == '0) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        grant   = (state == IDLE) && (dm_req || if_req);
        capture = (state == WAIT) && (cnt == '0);
    end

    assign stall_f = if_req & ~if_valid;
    assign stall_m = dm_req & ~dm_valid;

`ifdef MEM_ARB_PERF_EN
    mem_arb_perf_ctr u_perf_if (
        .clk   (clk),
        .rst   (rst),
        .en    (stall_f),
        .count (perf_if_wait)
    );

    mem_arb_perf_ctr u_perf_dm (
        .clk   (clk),
        .rst   (rst),
        .en    (stall_m),
        .count (perf_dm_wait)
    );
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

    localparam int L = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic [31:0] if_rdata;
    logic        if_valid;
    logic        stall_f;
    logic        dm_req = 1'b0;
    logic        dm_we = 1'b0;
    logic [31:0] dm_addr = '0;
    logic [31:0] dm_wdata = '0;
    logic [31:0] dm_rdata;
    logic        dm_valid;
    logic        stall_m;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
`ifdef MEM_ARB_PERF_EN
    logic [31:0] perf_if_wait;
    logic [31:0] perf_dm_wait;
`endif

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(L)) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_valid  (if_valid),
        .stall_f   (stall_f),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_rdata  (dm_rdata),
        .dm_valid  (dm_valid),
        .stall_m   (stall_m),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
`ifdef MEM_ARB_PERF_EN
        ,
        .perf_if_wait (perf_if_wait),
        .perf_dm_wait (perf_dm_wait)
`endif
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Memory device: one array serving the DUT, one shadow array for the model.
    logic [31:0] mem_arr    [logic [31:0]];
    logic [31:0] shadow_arr [logic [31:0]];
    logic [31:0] sched_data [16];
    logic        sched_v    [16];

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    always @(negedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                mem_arr[mem_addr] = mem_wdata;
            end else begin
                sched_data[(cyc + L) % 16] = mem_arr.exists(mem_addr) ? mem_arr[mem_addr]
                                                                      : init_word(mem_addr);
                sched_v[(cyc + L) % 16] = 1'b1;
            end
        end
        if (sched_v[cyc % 16]) begin
            mem_rdata = sched_data[cyc % 16];
            sched_v[cyc % 16] = 1'b0;
        end else begin
            mem_rdata = $urandom;
        end
    end

    // Transaction-level model: a grant at cycle g owns the port through cycle g+L+2.
    bit          model_on = 1'b0;
    bit          busy = 1'b0;
    int          g_cyc = 0;
    bit          g_dm = 1'b0;
    bit          g_we = 1'b0;
    logic [31:0] g_addr = '0;
    logic [31:0] g_wdata = '0;
    logic [31:0] g_data = '0;
    bit          e_mem_en = 1'b0;
    bit          e_mem_we = 1'b0;
    bit          e_if_valid = 1'b0;
    bit          e_dm_valid = 1'b0;
    logic [31:0] e_if_rdata = '0;
    logic [31:0] e_dm_rdata = '0;
    bit          dm_known = 1'b0;
    logic [31:0] e_perf_if = '0;
    logic [31:0] e_perf_dm = '0;

    always @(posedge clk) begin
        if (!rst) begin
            model_on   = 1'b1;
            busy       = 1'b0;
            e_mem_en   = 1'b0;
            e_mem_we   = 1'b0;
            e_if_valid = 1'b0;
            e_dm_valid = 1'b0;
            e_if_rdata = '0;
            e_dm_rdata = '0;
            dm_known   = 1'b1;
            e_perf_if  = '0;
            e_perf_dm  = '0;
        end else begin
            if (if_req && !e_if_valid && e_perf_if != 32'hFFFF_FFFF) e_perf_if = e_perf_if + 1;
            if (dm_req && !e_dm_valid && e_perf_dm != 32'hFFFF_FFFF) e_perf_dm = e_perf_dm + 1;
            if (busy && cyc > g_cyc + L + 2) busy = 1'b0;
            if (!busy && (dm_req || if_req)) begin
                busy    = 1'b1;
                g_cyc   = cyc;
                g_dm    = dm_req;
                g_we    = dm_req && dm_we;
                g_addr  = dm_req ? dm_addr : if_addr;
                g_wdata = dm_wdata;
                if (g_we) shadow_arr[g_addr] = g_wdata;
                else g_data = shadow_arr.exists(g_addr) ? shadow_arr[g_addr] : init_word(g_addr);
            end
            e_mem_en   = busy && (cyc + 1 == g_cyc + 1);
            e_mem_we   = e_mem_en && g_we;
            e_if_valid = busy && (cyc + 1 == g_cyc + L + 2) && !g_dm;
            e_dm_valid = busy && (cyc + 1 == g_cyc + L + 2) && g_dm;
            if (e_if_valid) e_if_rdata = g_data;
            if (e_dm_valid) begin
                if (g_we) dm_known = 1'b0;
                else begin
                    e_dm_rdata = g_data;
                    dm_known   = 1'b1;
                end
            end
        end
        cyc++;
    end

    always @(negedge clk) begin
        if (model_on) begin
            chk("mem_en", {31'd0, mem_en}, {31'd0, e_mem_en});
            chk("mem_we", {31'd0, mem_we}, {31'd0, e_mem_we});
            if (e_mem_en) chk("mem_addr", mem_addr, g_addr);
            if (e_mem_en && g_we) chk("mem_wdata", mem_wdata, g_wdata);
            chk("if_valid", {31'd0, if_valid}, {31'd0, e_if_valid});
            chk("dm_valid", {31'd0, dm_valid}, {31'd0, e_dm_valid});
            chk("if_rdata", if_rdata, e_if_rdata);
            if (dm_known) chk("dm_rdata", dm_rdata, e_dm_rdata);
            chk("stall_f", {31'd0, stall_f}, {31'd0, if_req & ~e_if_valid});
            chk("stall_m", {31'd0, stall_m}, {31'd0, dm_req & ~e_dm_valid});
`ifdef MEM_ARB_PERF_EN
            chk("perf_if_wait", perf_if_wait, e_perf_if);
            chk("perf_dm_wait", perf_dm_wait, e_perf_dm);
`endif
        end
    end

    task automatic step(input logic r, input logic ir, input logic [31:0] ia,
                        input logic dr, input logic dw, input logic [31:0] da,
                        input logic [31:0] dd);
        @(posedge clk);
        #1;
        rst = r; if_req = ir; if_addr = ia;
        dm_req = dr; dm_we = dw; dm_addr = da; dm_wdata = dd;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) sched_v[i] = 1'b0;
        mem_arr[32'h10] = 32'h0050_0093; shadow_arr[32'h10] = 32'h0050_0093;
        mem_arr[32'h20] = 32'h1234_5678; shadow_arr[32'h20] = 32'h1234_5678;
        mem_arr[32'h30] = 32'hCAFE_0030; shadow_arr[32'h30] = 32'hCAFE_0030;

        // Reset held two cycles with both requests high.
        for (int k = 0; k < 2; k++) step(1'b0, 1'b1, 32'h30, 1'b1, 1'b0, 32'h20, 32'h0);
        chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_if_rdata", if_rdata, 32'd0);
        chk("rst_dm_rdata", dm_rdata, 32'd0);
        chk("rst_if_valid", {31'd0, if_valid}, 32'd0);
        chk("rst_dm_valid", {31'd0, dm_valid}, 32'd0);

        // Simultaneous load 0x20 and fetch 0x30: data first, fetch waits.
        for (int k = 0; k <= 9; k++) begin
            if (k <= 4) step(1'b1, 1'b1, 32'h30, 1'b1, 1'b0, 32'h20, 32'h0);
            else        step(1'b1, 1'b1, 32'h30, 1'b0, 1'b0, 32'h20, 32'h0);
            if (k == 0) chk("sim_no_en_at_grant", {31'd0, mem_en}, 32'd0);
            if (k == 1) chk("sim_dm_addr", mem_addr, 32'h20);
            if (k == 3) chk("sim_dm_valid_c3", {31'd0, dm_valid}, 32'd0);
            if (k == 4) chk("sim_dm_valid_c4", {31'd0, dm_valid}, 32'd1);
            if (k == 4) chk("sim_dm_rdata", dm_rdata, 32'h1234_5678);
            if (k == 6) chk("sim_if_en_c6", {31'd0, mem_en}, 32'd1);
            if (k == 6) chk("sim_if_addr", mem_addr, 32'h30);
            if (k == 8) chk("sim_if_valid_c8", {31'd0, if_valid}, 32'd0);
            if (k == 9) chk("sim_if_valid_c9", {31'd0, if_valid}, 32'd1);
            if (k == 9) chk("sim_if_rdata", if_rdata, 32'hCAFE_0030);
        end
        idle(1);
`ifdef MEM_ARB_PERF_EN
        chk("perf_dm_lit", perf_dm_wait, 32'd4);
        chk("perf_if_lit", perf_if_wait, 32'd9);
`endif
        idle(1);

        // Single fetch 0x10.
        for (int k = 0; k <= 4; k++) begin
            step(1'b1, 1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0);
            if (k == 0) chk("f_stall_c0", {31'd0, stall_f}, 32'd1);
            if (k == 1) chk("f_mem_en_c1", {31'd0, mem_en}, 32'd1);
            if (k == 1) chk("f_mem_addr", mem_addr, 32'h10);
            if (k == 1) chk("f_mem_we", {31'd0, mem_we}, 32'd0);
            if (k == 2) chk("f_mem_en_c2", {31'd0, mem_en}, 32'd0);
            if (k == 3) chk("f_stall_c3", {31'd0, stall_f}, 32'd1);
            if (k == 4) chk("f_valid", {31'd0, if_valid}, 32'd1);
            if (k == 4) chk("f_rdata", if_rdata, 32'h0050_0093);
            if (k == 4) chk("f_stall_c4", {31'd0, stall_f}, 32'd0);
        end
        idle(1);

        // Store 0xDEADBEEF to 0x40, then fetch it back.
        for (int k = 0; k <= 4; k++) begin
            step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h40, 32'hDEAD_BEEF);
            if (k == 1) chk("s_mem_we_c1", {31'd0, mem_we}, 32'd1);
            if (k == 1) chk("s_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
            if (k == 1) chk("s_mem_addr", mem_addr, 32'h40);
            if (k == 2) chk("s_mem_we_c2", {31'd0, mem_we}, 32'd0);
            if (k == 4) chk("s_dm_valid", {31'd0, dm_valid}, 32'd1);
        end
        idle(1);
        for (int k = 0; k <= 4; k++) begin
            step(1'b1, 1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0);
            if (k == 4) chk("s_readback", if_rdata, 32'hDEAD_BEEF);
        end
        idle(1);

        // Reset in cycle 2 of a load; fetch from cycle 4.
        for (int k = 0; k <= 8; k++) begin
            if (k <= 1)      step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0);
            else if (k == 2) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h20, 32'h0);
            else if (k == 3) step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
            else             step(1'b1, 1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0);
            if (k >= 2) chk("r_no_dm_valid", {31'd0, dm_valid}, 32'd0);
            if (k == 3) chk("r_dm_rdata_cleared", dm_rdata, 32'd0);
            if (k == 7) chk("r_if_valid_c7", {31'd0, if_valid}, 32'd0);
            if (k == 8) chk("r_if_valid_c8", {31'd0, if_valid}, 32'd1);
            if (k == 8) chk("r_if_rdata", if_rdata, 32'h0050_0093);
        end
        idle(1);

        // Randomized traffic: held requests, occasional flushes, address jitter, resets.
        begin
            logic        r_ir = 1'b0;
            logic [31:0] r_ia = '0;
            logic        r_dr = 1'b0;
            logic        r_dw = 1'b0;
            logic [31:0] r_da = '0;
            logic [31:0] r_dd = '0;
            logic        pv_if = 1'b0;
            logic        pv_dm = 1'b0;
            for (int n = 0; n < 3000; n++) begin
                if (r_ir && !pv_if) begin
                    if ($urandom_range(0, 99) < 3) r_ir = 1'b0;
                    if ($urandom_range(0, 99) < 20) r_ia = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
                end else begin
                    r_ir = ($urandom_range(0, 99) < 40);
                    r_ia = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
                end
                if (r_dr && !pv_dm) begin
                    if ($urandom_range(0, 99) < 3) r_dr = 1'b0;
                    if ($urandom_range(0, 99) < 20) r_da = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
                    if ($urandom_range(0, 99) < 20) r_dd = $urandom;
                end else begin
                    r_dr = ($urandom_range(0, 99) < 30);
                    r_dw = $urandom_range(0, 1) == 1;
                    r_da = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
                    r_dd = $urandom;
                end
                step(($urandom_range(0, 299) != 0), r_ir, r_ia, r_dr, r_dw, r_da, r_dd);
                pv_if = if_valid;
                pv_dm = dm_valid;
            end
        end
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
